// File: rtl/encaps_seq_ctrl_pkg.sv
// Shared types and default constants for the encaps datapath sequencer.
// Imported by the sequencer top and its counter sub-module.
// Optional build macro used by this slice: SEQ_CTRL_STALL_EN.
package encaps_seq_ctrl_pkg;

  // Sequencer phases; the top keeps legacy-style localparam copies of these codes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  // Default geometry of the encaps datapath
  localparam int DEF_TRIT_GRP   = 5;
  localparam int DEF_PACK_LEN   = 68;
  localparam int DEF_ANS_IDX    = 52;
  localparam int DEF_NUM_ROUNDS = 3;
  localparam int DEF_STOP_AT    = 5;

  // Counter width for a value range of 0..range-1, never narrower than one bit
  function automatic int cntWidth(input int range);
    return (range < 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/encaps_seq_ctrl_if.sv
// Bundle of control and strobe signals between the encaps sequencer and its user.
// The master side launches sequences (and stalls them when SEQ_CTRL_STALL_EN is defined);
// the slave side is the sequencer driving enables, strobes and decodes.
interface encaps_seq_ctrl_if #(
  parameter int TW = 3,
  parameter int RW = 2
);

`ifdef SEQ_CTRL_STALL_EN
  logic          stall;
`endif
  logic          start;
  logic          sipo_t_en;
  logic          sipo_u_en;
  logic          sipo_p_en;
  logic          p3_rst1;
  logic [TW-1:0] p3_count;
  logic          sipo_p_stop;
  logic          hash_rst1;
  logic          hash_rst2;
  logic          hash_sp;
  logic          hash_ans;
  logic          hash_keccak;
  logic [RW-1:0] hash_round;
  logic          hash_fin;
  logic          halt_n;
  logic          done;

  modport master (
`ifdef SEQ_CTRL_STALL_EN
    output stall,
`endif
    output start,
    input  sipo_t_en, sipo_u_en, sipo_p_en, p3_rst1, p3_count, sipo_p_stop,
    input  hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_round,
    input  hash_fin, halt_n, done
  );

  modport slave (
`ifdef SEQ_CTRL_STALL_EN
    input  stall,
`endif
    input  start,
    output sipo_t_en, sipo_u_en, sipo_p_en, p3_rst1, p3_count, sipo_p_stop,
    output hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_round,
    output hash_fin, halt_n, done
  );

endinterface

// File: rtl/encaps_seq_ctrl_mod_counter.sv
// Modulo-N up counter with synchronous clear and count enable.
// Wrap from MODULUS-1 back to zero is an explicit compare so non-power-of-two moduli work.
module seq_mod_counter #(
  parameter int MODULUS = 5,
  parameter int W       = 3
) (
  input  logic         sipo_t_clk,
  input  logic         ovr_rst1,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] r_count;

  // Clear wins over enable so a relaunch always starts from zero
  always_ff @(posedge sipo_t_clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/encaps_seq_ctrl.sv
// Sequencer for the encaps datapath: ternary SIPO, PACK_S3 SIPO and SHA3 hash rounds.
// Counts trit groups (tcnt), pack bytes (pcnt) and hash rounds, then halts after the
// answer tick of the final round. All decodes are combinational from registered state.
// Optional build macro: SEQ_CTRL_STALL_EN adds a stall input that freezes the sequence.
module encaps_seq_ctrl
  import encaps_seq_ctrl_pkg::*;
#(
  parameter int TRIT_GRP   = DEF_TRIT_GRP,
  parameter int PACK_LEN   = DEF_PACK_LEN,
  parameter int ANS_IDX    = DEF_ANS_IDX,
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int STOP_AT    = DEF_STOP_AT
) (
  input  logic               sipo_t_clk,
  input  logic               ovr_rst1,
  encaps_seq_ctrl_if.slave   io_seq
);

  localparam int TW = cntWidth(TRIT_GRP);
  localparam int PW = cntWidth(PACK_LEN);
  localparam int RW = cntWidth(NUM_ROUNDS + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]    r_state;
  logic [RW-1:0] r_round;
  logic [TW-1:0] w_tcnt;
  logic [PW-1:0] w_pcnt;
  logic          w_stall;
  logic          w_run;
  logic          w_active;
  logic          w_start_acc;
  logic          w_p_tick;
  logic          w_ans;
  logic          w_final_rnd;
  logic          w_final_tick;
  logic          w_pcnt_clr;

`ifdef SEQ_CTRL_STALL_EN
  assign w_stall = io_seq.stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_run        = (r_state == ST_RUN);
  assign w_active     = w_run & ~w_stall;
  assign w_start_acc  = io_seq.start & ((r_state == ST_IDLE) | (r_state == ST_HALT));
  assign w_p_tick     = w_active & (w_tcnt == TW'(TRIT_GRP - 1));
  assign w_ans        = w_run & (w_pcnt == PW'(ANS_IDX));
  assign w_final_rnd  = (r_round == RW'(NUM_ROUNDS - 1));
  assign w_final_tick = w_p_tick & w_ans & w_final_rnd;
  assign w_pcnt_clr   = w_start_acc | w_final_tick;

  seq_mod_counter #(
    .MODULUS (TRIT_GRP),
    .W       (TW)
  ) u_tcnt (
    .sipo_t_clk (sipo_t_clk),
    .ovr_rst1   (ovr_rst1),
    .i_en       (w_active),
    .i_clr      (w_start_acc),
    .o_count    (w_tcnt)
  );

  seq_mod_counter #(
    .MODULUS (PACK_LEN),
    .W       (PW)
  ) u_pcnt (
    .sipo_t_clk (sipo_t_clk),
    .ovr_rst1   (ovr_rst1),
    .i_en       (w_p_tick),
    .i_clr      (w_pcnt_clr),
    .o_count    (w_pcnt)
  );

  // Round count advances on each answer tick; the last one parks it at NUM_ROUNDS
  always_ff @(posedge sipo_t_clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      r_round <= '0;
    end else if (w_start_acc) begin
      r_round <= '0;
    end else if (w_p_tick & w_ans) begin
      r_round <= w_final_rnd ? RW'(NUM_ROUNDS) : r_round + RW'(1);
    end
  end

  // Phase control: launch from IDLE or HALT, stop after the final answer tick
  always_ff @(posedge sipo_t_clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (io_seq.start) r_state <= ST_RUN;
        ST_RUN:  if (w_final_tick) r_state <= ST_HALT;
        ST_HALT: if (io_seq.start) r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_seq.sipo_t_en   = w_active;
  assign io_seq.sipo_u_en   = w_active;
  assign io_seq.sipo_p_en   = w_p_tick;
  assign io_seq.p3_rst1     = w_run & (w_tcnt == '0);
  assign io_seq.p3_count    = w_tcnt;
  assign io_seq.sipo_p_stop = w_run & (r_round != '0) & (w_pcnt == PW'(STOP_AT));
  assign io_seq.hash_rst1   = w_run & (w_pcnt == PW'(1)) & (r_round == '0);
  assign io_seq.hash_rst2   = w_run & ((w_pcnt == PW'(2)) | (w_pcnt == PW'(3)));
  assign io_seq.hash_sp     = w_run & (w_pcnt == PW'(1));
  assign io_seq.hash_ans    = w_ans;
  assign io_seq.hash_keccak = w_pcnt[0];
  assign io_seq.hash_round  = r_round;
  assign io_seq.hash_fin    = w_final_rnd;
  assign io_seq.halt_n      = (r_state != ST_HALT);
  assign io_seq.done        = (r_state == ST_HALT);

endmodule
